// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants for the SRAM port arbiter: FSM state encoding and
// the owner tag that records which requester holds the bus.
package sram_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// SRAM-like bus between the arbiter (master) and the SoC bus bridge (slave).
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                mem_req;
  logic                mem_wr;
  logic [DATA_W/8-1:0] mem_sel;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_addr_ok;
  logic                mem_data_ok;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_sel, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_sel, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/sram_port_arbiter_req_slot.sv
// Per-requester completion slot: holds the done flag and the registered
// read data, and derives the requester's stall from registered state only.
module sram_req_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              advance_i,
  input  logic              flush_i,
  input  logic              capture_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              done_o,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic              done_q, done_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // done survives until the whole pipeline moves on, so a held request is not re-issued
  always_comb begin
    done_d  = done_q;
    rdata_d = rdata_q;
    if (flush_i || advance_i) begin
      done_d = 1'b0;
    end else if (capture_i) begin
      done_d = 1'b1;
    end
    if (capture_i && load_i) begin
      rdata_d = rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign done_o  = done_q;
  assign stall_o = req_i & ~done_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like bus port between instruction fetch and the mem stage,
// one transaction at a time, and produces the per-requester stalls.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_stall,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_sel,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_stall,
  input  logic                ext_stall,
  input  logic                flush,
  sram_port_arbiter_if.master bus
);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                discard_q, discard_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_wr_q, mem_wr_d;
  logic [DATA_W/8-1:0] mem_sel_q, mem_sel_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                inst_done, data_done;
  logic                advance;
  logic                resp_keep;

  assign advance = ~inst_stall & ~data_stall & ~ext_stall;

  // A response that races a flush belongs to a squashed instruction and is dropped
  assign resp_keep = (state_q == ST_DATA) && bus.mem_data_ok && !discard_q && !flush;

  sram_req_slot #(.DATA_W(DATA_W)) u_inst_slot (
    .clk       (clk),
    .rst       (rst),
    .req_i     (inst_req),
    .advance_i (advance),
    .flush_i   (flush),
    .capture_i (resp_keep && (owner_q == OWNER_INST)),
    .load_i    (1'b1),
    .rdata_i   (bus.mem_rdata),
    .done_o    (inst_done),
    .stall_o   (inst_stall),
    .rdata_o   (inst_rdata)
  );

  sram_req_slot #(.DATA_W(DATA_W)) u_data_slot (
    .clk       (clk),
    .rst       (rst),
    .req_i     (data_req),
    .advance_i (advance),
    .flush_i   (flush),
    .capture_i (resp_keep && (owner_q == OWNER_DATA)),
    .load_i    (~mem_wr_q),
    .rdata_i   (bus.mem_rdata),
    .done_o    (data_done),
    .stall_o   (data_stall),
    .rdata_o   (data_rdata)
  );

  // Data side wins arbitration because it belongs to the older instruction
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    discard_d   = discard_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (flush && (state_q != ST_IDLE)) begin
      discard_d = 1'b1;
    end
    case (state_q)
      ST_IDLE: begin
        if (data_req && !data_done) begin
          owner_d     = OWNER_DATA;
          mem_wr_d    = data_wr;
          mem_sel_d   = data_sel;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
          mem_req_d   = 1'b1;
          state_d     = ST_ADDR;
        end else if (inst_req && !inst_done) begin
          owner_d     = OWNER_INST;
          mem_wr_d    = 1'b0;
          mem_sel_d   = '1;
          mem_addr_d  = inst_addr;
          mem_wdata_d = '0;
          mem_req_d   = 1'b1;
          state_d     = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (bus.mem_addr_ok) begin
          mem_req_d = 1'b0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.mem_data_ok) begin
          discard_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_INST;
      discard_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_sel_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      discard_q   <= discard_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.mem_sel   = mem_sel_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: a driver issues pipeline steps and
// predicts bus transactions and stall lengths; a bus model and monitor check them.
module tb_sram_port_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    int a;
    int d;
  } dly_t;

  typedef struct {
    int          instCnt;
    int          dataCnt;
    logic [31:0] instRd;
    logic [31:0] dataRd;
  } res_t;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_stall;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_stall;
  logic        ext_stall;
  logic        flush;

  int errors;
  int checks;

  txn_t txnQ[$];
  dly_t dlyQ[$];
  res_t resQ[$];

  logic [31:0] modelInst;
  logic [31:0] modelData;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_stall (inst_stall),
    .data_req   (data_req),
    .data_wr    (data_wr),
    .data_sel   (data_sel),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_stall (data_stall),
    .ext_stall  (ext_stall),
    .flush      (flush),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image seen through the bus; a few fixed words, the rest hashed from the address
  function automatic logic [31:0] memVal(input logic [31:0] addr);
    if (addr == 32'hBFC0_0000) return 32'h3C1D_8000;
    if (addr == 32'h8000_1000) return 32'h1234_5678;
    return {addr[15:0], ~addr[31:16]} ^ 32'h0F0F_1234;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  task automatic reportMissing(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got nothing expected an entry", name);
  endtask

  task automatic finishRun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // One pipeline step: present requests, predict bus traffic and stall lengths,
  // wait for completion, then hold the pipeline with ext_stall for 'hold' cycles.
  task automatic applyStimulus(
    input logic iReq, input logic [31:0] iAddr,
    input logic dReq, input logic dWr, input logic [3:0] dSel,
    input logic [31:0] dAddr, input logic [31:0] dWdata,
    input int aD, input int dD, input int aI, input int dI,
    input int hold, input int flushAt, input logic [31:0] newAddr, input int rstAt);
    int   cyc;
    int   lenD;
    int   lenI;
    res_t r;
    inst_req   = iReq;
    inst_addr  = iAddr;
    data_req   = dReq;
    data_wr    = dWr;
    data_sel   = dSel;
    data_addr  = dAddr;
    data_wdata = dWdata;
    ext_stall  = (hold > 0);
    flush      = 1'b0;
    rst        = 1'b0;
    lenD = 3 + aD + dD;
    lenI = 3 + aI + dI;
    r.dataCnt = dReq ? lenD : 0;
    r.instCnt = 0;
    if (dReq) begin
      txnQ.push_back('{dAddr, dWr, dSel, dWdata});
      dlyQ.push_back('{aD, dD});
      if (!dWr) modelData = memVal(dAddr);
    end
    if (iReq) begin
      dlyQ.push_back('{aI, dI});
      if (rstAt < 0) txnQ.push_back('{iAddr, 1'b0, 4'hF, 32'h0});
      if (flushAt >= 0) begin
        txnQ.push_back('{newAddr, 1'b0, 4'hF, 32'h0});
        dlyQ.push_back('{0, 0});
        r.instCnt = lenI + 3;
        modelInst = memVal(newAddr);
      end else if (rstAt >= 0) begin
        txnQ.push_back('{iAddr, 1'b0, 4'hF, 32'h0});
        dlyQ.push_back('{0, 0});
        r.instCnt = rstAt + 1 + 3;
        modelInst = memVal(iAddr);
        modelData = 32'h0;
      end else begin
        r.instCnt = (dReq ? lenD : 0) + lenI;
        modelInst = memVal(iAddr);
      end
    end
    r.instRd = modelInst;
    r.dataRd = modelData;
    resQ.push_back(r);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!inst_stall && !data_stall) break;
      if (cyc >= 300) begin
        checks++;
        errors++;
        $display("[TB] FAIL stepTimeout: got stall after %0d cycles expected completion", cyc);
        finishRun();
      end
      @(posedge clk);
      #1;
      cyc++;
      flush = (cyc == flushAt);
      rst   = (cyc == rstAt);
      if ((flushAt >= 0) && (cyc == flushAt + 1)) inst_addr = newAddr;
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    ext_stall = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Bus responder: addr_ok after 'a' extra cycles, data_ok after 'd' more, plus stray handshakes
  int   bfmPhase;
  int   bfmCnt;
  int   bfmDcnt;
  logic [31:0] bfmAddr;
  logic bfmWr;
  dly_t bfmDly;

  initial begin
    bus.mem_addr_ok = 1'b0;
    bus.mem_data_ok = 1'b0;
    bus.mem_rdata   = 32'h0;
    bfmPhase = 0;
    forever begin
      @(posedge clk);
      #2;
      bus.mem_addr_ok = 1'b0;
      bus.mem_data_ok = 1'b0;
      bus.mem_rdata   = $urandom;
      if (rst) begin
        bfmPhase = 0;
      end else begin
        if (bfmPhase == 0) begin
          if (bus.mem_req) begin
            if (dlyQ.size() == 0) begin
              reportMissing("busDelayEntry");
              bfmDly = '{0, 0};
            end else begin
              bfmDly = dlyQ.pop_front();
            end
            bfmCnt   = bfmDly.a;
            bfmDcnt  = bfmDly.d;
            bfmPhase = 1;
          end else begin
            bus.mem_addr_ok = ($urandom_range(0, 3) == 0);
            bus.mem_data_ok = ($urandom_range(0, 3) == 0);
          end
        end
        if (bfmPhase == 1) begin
          if (bfmCnt == 0) begin
            bus.mem_addr_ok = 1'b1;
            bfmAddr  = bus.mem_addr;
            bfmWr    = bus.mem_wr;
            bfmPhase = 2;
          end else begin
            bfmCnt--;
            bus.mem_data_ok = ($urandom_range(0, 2) == 0);
          end
        end else if (bfmPhase == 2) begin
          if (bfmDcnt == 0) begin
            bus.mem_data_ok = 1'b1;
            if (!bfmWr) bus.mem_rdata = memVal(bfmAddr);
            bfmPhase = 0;
          end else begin
            bfmDcnt--;
            bus.mem_addr_ok = ($urandom_range(0, 2) == 0);
          end
        end
      end
    end
  end

  // Monitor: bus transactions against the predicted list, stall lengths and rdata on completion
  logic        prevRst;
  logic        inTxn;
  logic        checked;
  int          icnt;
  int          dcnt;
  logic [31:0] heldAddr;
  logic [31:0] heldWdata;
  logic [31:0] heldCtl;
  txn_t        expTxn;
  res_t        curRes;

  initial begin
    prevRst = 1'b0;
    inTxn   = 1'b0;
    checked = 1'b0;
    icnt    = 0;
    dcnt    = 0;
    forever begin
      @(negedge clk);
      if (prevRst) begin
        checkOutput("rstMemReq", {31'b0, bus.mem_req}, 32'h0);
        checkOutput("rstMemAddr", bus.mem_addr, 32'h0);
        checkOutput("rstInstRdata", inst_rdata, 32'h0);
        checkOutput("rstDataRdata", data_rdata, 32'h0);
        checkOutput("rstInstStall", {31'b0, inst_stall}, {31'b0, inst_req});
        checkOutput("rstDataStall", {31'b0, data_stall}, {31'b0, data_req});
      end
      prevRst = rst;
      if (rst) begin
        inTxn = 1'b0;
      end else if (bus.mem_req) begin
        if (!inTxn) begin
          heldAddr  = bus.mem_addr;
          heldWdata = bus.mem_wdata;
          heldCtl   = {27'b0, bus.mem_wr, bus.mem_sel};
          inTxn     = 1'b1;
        end else begin
          checkOutput("busAddrStable", bus.mem_addr, heldAddr);
          checkOutput("busWdataStable", bus.mem_wdata, heldWdata);
          checkOutput("busCtlStable", {27'b0, bus.mem_wr, bus.mem_sel}, heldCtl);
        end
        if (bus.mem_addr_ok) begin
          inTxn = 1'b0;
          if (txnQ.size() == 0) begin
            reportMissing("busTxnUnexpected");
          end else begin
            expTxn = txnQ.pop_front();
            checkOutput("busAddr", bus.mem_addr, expTxn.addr);
            checkOutput("busWrSel", {27'b0, bus.mem_wr, bus.mem_sel}, {27'b0, expTxn.wr, expTxn.sel});
            if (expTxn.wr) checkOutput("busWdata", bus.mem_wdata, expTxn.wdata);
          end
        end
      end
      if (inst_req || data_req) begin
        if (!checked) begin
          if (inst_stall) icnt++;
          if (data_stall) dcnt++;
          if (!inst_stall && !data_stall) begin
            if (resQ.size() == 0) begin
              reportMissing("stepResult");
            end else begin
              curRes = resQ.pop_front();
              checkOutput("instStallCycles", icnt, curRes.instCnt);
              checkOutput("dataStallCycles", dcnt, curRes.dataCnt);
              checkOutput("instRdata", inst_rdata, curRes.instRd);
              checkOutput("dataRdata", data_rdata, curRes.dataRd);
            end
            checked = 1'b1;
            icnt    = 0;
            dcnt    = 0;
          end
        end else begin
          checkOutput("holdInstStall", {31'b0, inst_stall}, 32'h0);
          checkOutput("holdDataStall", {31'b0, data_stall}, 32'h0);
          checkOutput("holdInstRdata", inst_rdata, curRes.instRd);
          checkOutput("holdDataRdata", data_rdata, curRes.dataRd);
        end
        if (checked && !ext_stall && !inst_stall && !data_stall) checked = 1'b0;
      end
    end
  end

  logic        rIReq;
  logic        rDReq;
  logic        rDWr;
  logic [3:0]  rSel;
  logic [31:0] rIAddr;
  logic [31:0] rDAddr;
  logic [31:0] rWdata;

  initial begin
    errors     = 0;
    checks     = 0;
    modelInst  = 32'h0;
    modelData  = 32'h0;
    rst        = 1'b1;
    inst_req   = 1'b0;
    inst_addr  = 32'h0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_sel   = 4'h0;
    data_addr  = 32'h0;
    data_wdata = 32'h0;
    ext_stall  = 1'b0;
    flush      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    $display("[TB] directed steps");
    applyStimulus(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                  0, 0, 0, 0, 0, -1, 32'h0, -1);
    applyStimulus(1'b1, 32'hBFC0_0004, 1'b1, 1'b0, 4'hF, 32'h8000_1000, 32'h0,
                  0, 0, 0, 0, 1, -1, 32'h0, -1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h8000_2000, 32'hAABB_CCDD,
                  0, 0, 0, 0, 5, -1, 32'h0, -1);
    applyStimulus(1'b1, 32'hBFC0_0008, 1'b1, 1'b1, 4'b1100, 32'h8000_3004, 32'h1122_3344,
                  3, 2, 3, 2, 0, -1, 32'h0, -1);
    applyStimulus(1'b1, 32'hBFC0_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                  0, 0, 0, 3, 0, 3, 32'hBFC0_0380, -1);
    applyStimulus(1'b1, 32'hBFC0_0020, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                  0, 0, 0, 3, 0, 5, 32'hBFC0_0380, -1);
    applyStimulus(1'b1, 32'h8000_0200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                  0, 0, 5, 0, 0, -1, 32'h0, 2);
    $display("[TB] random steps");
    for (int s = 0; s < 60; s++) begin
      rIReq  = ($urandom_range(0, 3) != 0);
      rDReq  = ($urandom_range(0, 1) == 1);
      if (!rIReq && !rDReq) rIReq = 1'b1;
      rDWr   = ($urandom_range(0, 1) == 1);
      rSel   = 4'($urandom_range(0, 15));
      rIAddr = $urandom & 32'hFFFF_FFFC;
      rDAddr = $urandom & 32'hFFFF_FFFC;
      rWdata = $urandom;
      applyStimulus(rIReq, rIAddr, rDReq, rDWr, rSel, rDAddr, rWdata,
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), -1, 32'h0, -1);
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("txnQueueDrained", txnQ.size(), 32'h0);
    checkOutput("delayQueueDrained", dlyQ.size(), 32'h0);
    checkOutput("resultQueueDrained", resQ.size(), 32'h0);
    finishRun();
  end

endmodule
